key_scan: RTL and testbench

KEY_SCAN -- requirements
Module: key_scan

---
 rtl/key_scan_pkg.sv | 26 ++
 rtl/key_channel.sv | 114 +++++++++++
 rtl/key_scan.sv | 59 +++++
 tb/tb_key_scan.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// Shared definitions for the key scanner: per-key FSM encoding, default timing
// constants and the timer sizing rule.
package key_scan_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } key_state_t;

    localparam int DEF_CLK_FREQ       = 50_000_000;
    localparam int DEF_DEBOUNCE_CYC   = 1_000_000;
    localparam int DEF_REPEAT_DLY_CYC = 25_000_000;
    localparam int DEF_REPEAT_PER_CYC = 5_000_000;

    // Wide enough for the longest interval, so the counter never wraps.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button: 2-flop synchronizer, press/release debounce FSM and an
// optional auto-repeat generator. Emits a registered one-cycle pulse per event.
module key_channel
    import key_scan_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DLY_CYC = DEF_REPEAT_DLY_CYC,
    parameter int REPEAT_PER_CYC = DEF_REPEAT_PER_CYC,
    parameter bit REPEAT_EN      = 1'b1,
    parameter int TIMER_W        = timer_width(DEBOUNCE_CYC, REPEAT_DLY_CYC, REPEAT_PER_CYC)
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic pulse
);

    // The cycle that leaves IDLE/HELD already counts as the first stable one.
    localparam logic [TIMER_W-1:0] DB_LAST  = TIMER_W'(DEBOUNCE_CYC - 2);
    localparam logic [TIMER_W-1:0] DLY_LAST = TIMER_W'(REPEAT_DLY_CYC - 1);
    localparam logic [TIMER_W-1:0] PER_LAST = TIMER_W'(REPEAT_PER_CYC - 1);

    logic               sync_p0, sync_p1;
    logic               pressed;
    key_state_t         state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic               repeating, repeating_nxt;
    logic               rep_due;
    logic               pulse_nxt;

    assign pressed = ~sync_p1;
    assign rep_due = repeating ? (timer == PER_LAST) : (timer == DLY_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0   <= 1'b1;
            sync_p1   <= 1'b1;
            state     <= IDLE;
            timer     <= '0;
            repeating <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            sync_p0   <= key_raw;
            sync_p1   <= sync_p0;
            state     <= state_nxt;
            timer     <= timer_nxt;
            repeating <= repeating_nxt;
            pulse     <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        repeating_nxt = repeating;
        case (state)
            IDLE: begin
                if (pressed) begin
                    state_nxt = PRESS_DB;
                    timer_nxt = '0;
                end
            end
            PRESS_DB: begin
                if (!pressed) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (timer == DB_LAST) begin
                    state_nxt     = HELD;
                    timer_nxt     = '0;
                    repeating_nxt = 1'b0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_nxt = REL_DB;
                    timer_nxt = '0;
                end else if (REPEAT_EN) begin
                    // Reload on every repeat so an indefinite hold never wraps.
                    if (rep_due) begin
                        timer_nxt     = '0;
                        repeating_nxt = 1'b1;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
            end
            REL_DB: begin
                if (pressed) begin
                    state_nxt     = HELD;
                    timer_nxt     = '0;
                    repeating_nxt = 1'b0;
                end else if (timer == DB_LAST) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pulse_nxt = 1'b0;
        case (state)
            PRESS_DB: pulse_nxt = pressed && (timer == DB_LAST);
            HELD:     pulse_nxt = REPEAT_EN && pressed && rep_due;
            default:  pulse_nxt = 1'b0;
        endcase
    end

endmodule

// File: rtl/key_scan.sv
// Three independent debounced key channels: mode (no repeat), up and down
// (with auto-repeat).
module key_scan
    import key_scan_pkg::*;
#(
    parameter int CLK_FREQ       = DEF_CLK_FREQ,
    parameter int DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DLY_CYC = DEF_REPEAT_DLY_CYC,
    parameter int REPEAT_PER_CYC = DEF_REPEAT_PER_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_in,
    output logic       key1,
    output logic       key2,
    output logic       key3
);

    if (CLK_FREQ <= 0 || DEBOUNCE_CYC < 2) begin : g_param_check
        $error("key_scan: CLK_FREQ must be positive and DEBOUNCE_CYC at least 2");
    end

    key_channel #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .REPEAT_DLY_CYC(REPEAT_DLY_CYC),
        .REPEAT_PER_CYC(REPEAT_PER_CYC),
        .REPEAT_EN     (1'b0)
    ) u_mode (
        .clk    (clk),
        .rst    (rst),
        .key_raw(key_in[0]),
        .pulse  (key1)
    );

    key_channel #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .REPEAT_DLY_CYC(REPEAT_DLY_CYC),
        .REPEAT_PER_CYC(REPEAT_PER_CYC),
        .REPEAT_EN     (1'b1)
    ) u_up (
        .clk    (clk),
        .rst    (rst),
        .key_raw(key_in[1]),
        .pulse  (key2)
    );

    key_channel #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .REPEAT_DLY_CYC(REPEAT_DLY_CYC),
        .REPEAT_PER_CYC(REPEAT_PER_CYC),
        .REPEAT_EN     (1'b1)
    ) u_down (
        .clk    (clk),
        .rst    (rst),
        .key_raw(key_in[2]),
        .pulse  (key3)
    );

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: directed scenarios plus random key activity, every cycle
// compared against a run-length based reference model of the debounce rules.
module tb_key_scan;

    localparam int DB    = 16;
    localparam int DLY   = 100;
    localparam int PER   = 20;
    localparam int DEPTH = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] key_in;
    logic       key1, key2, key3;

    always #5 clk = ~clk;

    key_scan #(
        .DEBOUNCE_CYC  (DB),
        .REPEAT_DLY_CYC(DLY),
        .REPEAT_PER_CYC(PER)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .key_in(key_in),
        .key1  (key1),
        .key2  (key2),
        .key3  (key3)
    );

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         last_rst = -100;
    logic [2:0] raw_h [DEPTH];

    // Reference model state: accepted level and run lengths of the seen level.
    bit down  [3];
    int zrun  [3];
    int orun  [3];
    int anchor[3];
    bit exp_p [3];

    int cnt    [3];
    int first_t[3];
    int last_t [3];

    task automatic check(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Level seen by the debounce logic lags the pin by two cycles and reads
    // as released for two cycles after any reset cycle.
    task automatic model_step(input int k);
        bit lvl;
        int n;
        lvl = (cyc - last_rst <= 2) ? 1'b1 : raw_h[(cyc - 2) % DEPTH][k];
        exp_p[k] = 1'b0;
        if (!lvl) begin
            zrun[k]++;
            orun[k] = 0;
        end else begin
            orun[k]++;
            zrun[k] = 0;
        end
        if (!down[k]) begin
            if (zrun[k] == DB) begin
                down[k]   = 1'b1;
                anchor[k] = cyc;
                exp_p[k]  = 1'b1;
            end
        end else if (lvl) begin
            if (orun[k] == DB) down[k] = 1'b0;
        end else if (zrun[k] == 1) begin
            anchor[k] = cyc;
        end else if (k != 0) begin
            n = cyc - anchor[k];
            if (n >= DLY && (n - DLY) % PER == 0) exp_p[k] = 1'b1;
        end
    endtask

    task automatic tick();
        logic [2:0] obs;
        @(posedge clk);
        cyc++;
        raw_h[cyc % DEPTH] = key_in;
        if (rst) begin
            last_rst = cyc;
            for (int k = 0; k < 3; k++) begin
                down[k]  = 1'b0;
                zrun[k]  = 0;
                orun[k]  = 0;
                exp_p[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) model_step(k);
        end
        @(negedge clk);
        obs = {key3, key2, key1};
        for (int k = 0; k < 3; k++) begin
            check($sformatf("key%0d_cyc%0d", k + 1, cyc), int'(obs[k]), int'(exp_p[k]));
            if (obs[k]) begin
                cnt[k]++;
                if (first_t[k] < 0) first_t[k] = cyc;
                last_t[k] = cyc;
            end
        end
    endtask

    task automatic clear_log();
        for (int k = 0; k < 3; k++) begin
            cnt[k]     = 0;
            first_t[k] = -1;
            last_t[k]  = -1;
        end
    endtask

    initial begin
        int t0;
        int rem[3];

        rst    = 1'b1;
        key_in = 3'b111;
        for (int k = 0; k < 3; k++) begin
            down[k]   = 1'b0;
            zrun[k]   = 0;
            orun[k]   = 0;
            anchor[k] = 0;
            exp_p[k]  = 1'b0;
            rem[k]    = 0;
        end
        clear_log();
        repeat (3) tick();
        check("reset_outputs", int'({key3, key2, key1}), 0);
        rst = 1'b0;
        repeat (5) tick();

        // Clean mode-key press, then release
        clear_log();
        t0 = cyc;
        key_in = 3'b110;
        repeat (40) tick();
        key_in = 3'b111;
        repeat (40) tick();
        check("clean_count", cnt[0], 1);
        check("clean_latency", first_t[0] - t0, 18);
        check("clean_others", cnt[1] + cnt[2], 0);

        // Bouncing up-key settles low
        clear_log();
        for (int s = 0; s < 12; s++) begin
            key_in[1] = (s % 2 == 1);
            repeat (5) tick();
        end
        t0 = cyc;
        key_in[1] = 1'b0;
        repeat (30) tick();
        key_in[1] = 1'b1;
        repeat (40) tick();
        check("bounce_count", cnt[1], 1);
        check("bounce_latency", first_t[1] - t0, 18);

        // Long hold on down-key auto-repeats; mode-key does not
        clear_log();
        t0 = cyc;
        key_in = 3'b011;
        repeat (200) tick();
        key_in = 3'b111;
        repeat (40) tick();
        check("hold3_count", cnt[2], 6);
        check("hold3_first", first_t[2] - t0, 18);
        check("hold3_last", last_t[2] - t0, 198);
        clear_log();
        key_in = 3'b110;
        repeat (200) tick();
        key_in = 3'b111;
        repeat (40) tick();
        check("hold1_count", cnt[0], 1);

        // Simultaneous presses
        clear_log();
        t0 = cyc;
        key_in = 3'b100;
        repeat (30) tick();
        key_in = 3'b111;
        repeat (40) tick();
        check("simul_count1", cnt[0], 1);
        check("simul_count2", cnt[1], 1);
        check("simul_time1", first_t[0] - t0, 18);
        check("simul_time2", first_t[1] - t0, 18);

        // Reset in the middle of press debounce with the key still held
        clear_log();
        key_in = 3'b011;
        repeat (13) tick();
        rst = 1'b1;
        repeat (3) tick();
        check("rst_no_pulse", cnt[2], 0);
        rst = 1'b0;
        t0 = cyc;
        repeat (40) tick();
        key_in = 3'b111;
        repeat (40) tick();
        check("rst_count", cnt[2], 1);
        check("rst_latency", first_t[2] - t0, DB + 2);

        // Short release glitch during a hold
        clear_log();
        key_in = 3'b110;
        repeat (50) tick();
        key_in = 3'b111;
        repeat (5) tick();
        key_in = 3'b110;
        repeat (50) tick();
        key_in = 3'b111;
        repeat (40) tick();
        check("glitch_count", cnt[0], 1);

        // Random key activity with occasional reset
        for (int i = 0; i < 1200; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (rem[k] == 0) begin
                    key_in[k] = ~key_in[k];
                    rem[k] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(100, 170))
                                                         : int'($urandom_range(1, 30));
                end
                rem[k]--;
            end
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst    = 1'b0;
        key_in = 3'b111;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
